// File: rtl/rv32i_data_memory.sv
// RV32I data memory: word-addressed RAM with byte enables plus a small MMIO block
// (64-bit cycle counter, TOHOST halt register, SCRATCH). Reads are registered, read-first.
module rv32i_data_memory #(
    parameter int DEPTH_WORDS = 4096,
    parameter     INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_write,
    input  logic        memory_read,
    input  logic [31:0] memory_address,
    input  logic [3:0]  memory_byteenable,
    input  logic [31:0] memory_write_data,
    output logic [31:0] memory_read_data,
    output logic        halt,
    output logic [31:0] halt_code,
    output logic        access_error
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        MMIO_CYCLE_LO = 2'd0,
        MMIO_CYCLE_HI = 2'd1,
        MMIO_TOHOST   = 2'd2,
        MMIO_SCRATCH  = 2'd3
    } mmio_reg_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) res[8*k +: 8] = new_v[8*k +: 8];
        end
        return res;
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] ram_idx;
    logic          is_mmio;
    mmio_reg_e     mmio_sel;
    logic          be_legal;
    logic          unused_addr_bits;

    assign ram_idx  = memory_address[AW+1:2];
    assign is_mmio  = memory_address[31];
    assign mmio_sel = mmio_reg_e'(memory_address[3:2]);
    // Only the low word-index bits decode RAM; the rest alias by design.
    assign unused_addr_bits = ^{memory_address[30:AW+2], memory_address[1:0]};

    always_comb begin
        case (memory_byteenable)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
            default:                   be_legal = 1'b0;
        endcase
    end

    logic [31:0] rdata_q,     rdata_d;
    logic [63:0] cycle_q,     cycle_d;
    logic [31:0] snap_q,      snap_d;
    logic [31:0] tohost_q,    tohost_d;
    logic [31:0] scratch_q,   scratch_d;
    logic        halt_q,      halt_d;
    logic [31:0] halt_code_q, halt_code_d;
    logic        err_q,       err_d;
    logic [31:0] tohost_merged;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        rdata_d       = rdata_q;
        cycle_d       = cycle_q + 64'd1;
        snap_d        = snap_q;
        tohost_d      = tohost_q;
        scratch_d     = scratch_q;
        halt_d        = halt_q;
        halt_code_d   = halt_code_q;
        err_d         = memory_write && (memory_byteenable != 4'b0000) && !be_legal;
        tohost_merged = merge_bytes(tohost_q, memory_write_data, memory_byteenable);

        // Reads use pre-edge state, which gives read-first behaviour everywhere.
        if (memory_read) begin
            if (!is_mmio) begin
                rdata_d = mem[ram_idx];
            end else begin
                case (mmio_sel)
                    MMIO_CYCLE_LO: begin
                        rdata_d = cycle_q[31:0];
                        snap_d  = cycle_q[63:32];
                    end
                    MMIO_CYCLE_HI: rdata_d = snap_q;
                    MMIO_TOHOST:   rdata_d = tohost_q;
                    MMIO_SCRATCH:  rdata_d = scratch_q;
                    default:       rdata_d = rdata_q;
                endcase
            end
        end

        if (memory_write && is_mmio) begin
            case (mmio_sel)
                MMIO_TOHOST: begin
                    if (!halt_q) begin
                        tohost_d = tohost_merged;
                        if (tohost_merged != 32'd0) begin
                            halt_d      = 1'b1;
                            halt_code_d = tohost_merged;
                        end
                    end
                end
                MMIO_SCRATCH: scratch_d = merge_bytes(scratch_q, memory_write_data, memory_byteenable);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            rdata_q     <= 32'd0;
            cycle_q     <= 64'd0;
            snap_q      <= 32'd0;
            tohost_q    <= 32'd0;
            scratch_q   <= 32'd0;
            halt_q      <= 1'b0;
            halt_code_q <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            rdata_q     <= rdata_d;
            cycle_q     <= cycle_d;
            snap_q      <= snap_d;
            tohost_q    <= tohost_d;
            scratch_q   <= scratch_d;
            halt_q      <= halt_d;
            halt_code_q <= halt_code_d;
            err_q       <= err_d;
        end
    end

    // NOTE: the RAM array is deliberately not reset; reset only blocks writes so contents survive.
    always_ff @(posedge clk) begin
        if (reset && memory_write && !is_mmio) begin
            for (int k = 0; k < 4; k++) begin
                if (memory_byteenable[k]) mem[ram_idx][8*k +: 8] <= memory_write_data[8*k +: 8];
            end
        end
    end

    assign memory_read_data = rdata_q;
    assign halt             = halt_q;
    assign halt_code        = halt_code_q;
    assign access_error     = err_q;

endmodule

// File: tb/tb_rv32i_data_memory.sv
// Self-checking bench for rv32i_data_memory: directed scenarios plus randomized traffic
// compared against a transaction-level reference model kept in this file.
module tb_rv32i_data_memory;

    localparam int DEPTH = 4096;
    localparam logic [31:0] A_CYC_LO  = 32'h8000_0000;
    localparam logic [31:0] A_CYC_HI  = 32'h8000_0004;
    localparam logic [31:0] A_TOHOST  = 32'h8000_0008;
    localparam logic [31:0] A_SCRATCH = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memory_write = 1'b0;
    logic        memory_read = 1'b0;
    logic [31:0] memory_address = 32'd0;
    logic [3:0]  memory_byteenable = 4'd0;
    logic [31:0] memory_write_data = 32'd0;
    logic [31:0] memory_read_data;
    logic        halt;
    logic [31:0] halt_code;
    logic        access_error;

    int total = 0;
    int bad = 0;

    rv32i_data_memory #(
        .DEPTH_WORDS(DEPTH),
        .INIT_FILE  ("")
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .memory_write     (memory_write),
        .memory_read      (memory_read),
        .memory_address   (memory_address),
        .memory_byteenable(memory_byteenable),
        .memory_write_data(memory_write_data),
        .memory_read_data (memory_read_data),
        .halt             (halt),
        .halt_code        (halt_code),
        .access_error     (access_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    // Reference model state
    logic [31:0] ram_m [int];
    logic [31:0] m_rdata = 32'd0;
    bit          m_rd_known = 1'b1;
    logic [63:0] m_cnt = 64'd0;
    logic [31:0] m_snap = 32'd0;
    logic [31:0] m_tohost = 32'd0;
    logic [31:0] m_scratch = 32'd0;
    bit          m_halt = 1'b0;
    logic [31:0] m_code = 32'd0;
    bit          m_err = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r = o;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    task automatic model_edge(input bit rst_v, input bit w, input bit r, input logic [31:0] a,
                              input logic [3:0] be, input logic [31:0] d);
        int idx;
        int off;
        logic [31:0] mv;
        idx = int'((a >> 2) % DEPTH);
        off = int'(a[3:0]);
        if (!rst_v) begin
            m_rdata = 0; m_rd_known = 1; m_cnt = 0; m_snap = 0; m_tohost = 0;
            m_scratch = 0; m_halt = 0; m_code = 0; m_err = 0;
            return;
        end
        if (r) begin
            if (!a[31]) begin
                m_rd_known = ram_m.exists(idx);
                m_rdata = m_rd_known ? ram_m[idx] : 32'd0;
            end else begin
                m_rd_known = 1;
                if (off == 0) begin m_rdata = m_cnt[31:0]; m_snap = m_cnt[63:32]; end
                else if (off == 4) m_rdata = m_snap;
                else if (off == 8) m_rdata = m_tohost;
                else m_rdata = m_scratch;
            end
        end
        if (w) begin
            if (!a[31]) begin
                if (be != 0) ram_m[idx] = merge(ram_m.exists(idx) ? ram_m[idx] : 32'd0, d, be);
            end else if (off == 8 && !m_halt) begin
                mv = merge(m_tohost, d, be);
                m_tohost = mv;
                if (mv != 0) begin m_halt = 1; m_code = mv; end
            end else if (off == 12) begin
                m_scratch = merge(m_scratch, d, be);
            end
        end
        m_err = w && (be != 0) && !(be inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF});
        m_cnt = m_cnt + 1;
    endtask

    task automatic step(input bit rst_v, input bit w, input bit r, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] d);
        reset = rst_v; memory_write = w; memory_read = r;
        memory_address = a; memory_byteenable = be; memory_write_data = d;
        @(posedge clk);
        model_edge(rst_v, w, r, a, be, d);
        #1;
        reset = 1'b1; memory_write = 1'b0; memory_read = 1'b0; memory_byteenable = 4'd0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        step(1, 1, 0, a, be, d);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1, 0, 1, a, 4'd0, 32'd0);
    endtask

    task automatic test_reset;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        total++; if (memory_read_data !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h want 0", memory_read_data); end
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL reset_halt: got %b want 0", halt); end
        total++; if (halt_code !== 32'd0) begin bad++; $display("FAIL reset_code: got %h want 0", halt_code); end
        total++; if (access_error !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", access_error); end
    endtask

    task automatic test_ram_basic;
        wr(32'h100, 4'hF, 32'hDEADBEEF);
        rd(32'h100);
        total++; if (memory_read_data !== 32'hDEADBEEF) begin bad++; $display("FAIL ram_rd: got %h want deadbeef", memory_read_data); end
        step(1, 0, 0, 0, 0, 0);
        total++; if (memory_read_data !== 32'hDEADBEEF) begin bad++; $display("FAIL ram_hold: got %h want deadbeef", memory_read_data); end
        rd(32'h100 + DEPTH * 4 + 32'h3);
        total++; if (memory_read_data !== 32'hDEADBEEF) begin bad++; $display("FAIL ram_alias: got %h want deadbeef", memory_read_data); end
    endtask

    task automatic test_byte_enable;
        wr(32'h104, 4'hF, 32'h11223344);
        wr(32'h104, 4'b0010, 32'h0000AA00);
        total++; if (access_error !== 1'b0) begin bad++; $display("FAIL be_legal_err: got %b want 0", access_error); end
        rd(32'h104);
        total++; if (memory_read_data !== 32'h1122AA44) begin bad++; $display("FAIL be_merge: got %h want 1122aa44", memory_read_data); end
        wr(32'h108, 4'hF, 32'h00000000);
        wr(32'h108, 4'b0101, 32'hA1B2C3D4);
        total++; if (access_error !== 1'b1) begin bad++; $display("FAIL be_err_pulse: got %b want 1", access_error); end
        step(1, 0, 0, 0, 0, 0);
        total++; if (access_error !== 1'b0) begin bad++; $display("FAIL be_err_clear: got %b want 0", access_error); end
        wr(32'h108, 4'b0000, 32'hFFFFFFFF);
        total++; if (access_error !== 1'b0) begin bad++; $display("FAIL be_zero_err: got %b want 0", access_error); end
        rd(32'h108);
        total++; if (memory_read_data !== 32'h00B200D4) begin bad++; $display("FAIL be_illegal_data: got %h want 00b200d4", memory_read_data); end
    endtask

    task automatic test_read_write_same;
        wr(32'h200, 4'hF, 32'h1);
        step(1, 1, 1, 32'h200, 4'hF, 32'h2);
        total++; if (memory_read_data !== 32'h1) begin bad++; $display("FAIL rw_old: got %h want 1", memory_read_data); end
        rd(32'h200);
        total++; if (memory_read_data !== 32'h2) begin bad++; $display("FAIL rw_new: got %h want 2", memory_read_data); end
        reset = 1'b1;
        step(1, 1, 1, 32'h200, 4'hF, 32'h0);
        step(1, 1, 1, 32'h300, 4'hF, 32'h7); // read 0x300 old value unknown: overwritten below
        step(1, 1, 1, 32'h200, 4'hF, 32'h9);
        wr(32'h304, 4'hF, 32'h55);
        step(1, 1, 1, 32'h304, 4'hF, 32'h66);
        total++; if (memory_read_data !== 32'h55) begin bad++; $display("FAIL rw_diff_rd: got %h want 55", memory_read_data); end
        step(1, 1, 1, 32'h300, 4'hF, 32'h8);
        total++; if (memory_read_data !== 32'h7) begin bad++; $display("FAIL rw_diff_wr: got %h want 7", memory_read_data); end
    endtask

    task automatic test_cycle;
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0);
        rd(A_CYC_LO);
        total++; if (memory_read_data !== 32'd10) begin bad++; $display("FAIL cyc_lo: got %0d want 10", memory_read_data); end
        wr(A_CYC_LO, 4'hF, 32'h12345678);
        wr(A_CYC_HI, 4'hF, 32'h12345678);
        rd(A_CYC_HI);
        total++; if (memory_read_data !== 32'd0) begin bad++; $display("FAIL cyc_hi: got %h want 0", memory_read_data); end
        rd(A_CYC_LO);
        total++; if (memory_read_data !== 32'd14) begin bad++; $display("FAIL cyc_wr_ignored: got %0d want 14", memory_read_data); end
        force dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.cycle_q;
        m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        rd(A_CYC_LO);
        total++; if (memory_read_data !== 32'hFFFFFFFF) begin bad++; $display("FAIL cyc_max: got %h want ffffffff", memory_read_data); end
        rd(A_CYC_LO);
        total++; if (memory_read_data !== 32'd0) begin bad++; $display("FAIL cyc_wrap_lo: got %h want 0", memory_read_data); end
        rd(A_CYC_HI);
        total++; if (memory_read_data !== 32'd0) begin bad++; $display("FAIL cyc_wrap_hi: got %h want 0", memory_read_data); end
    endtask

    task automatic test_tohost;
        step(0, 0, 0, 0, 0, 0);
        wr(A_TOHOST, 4'hF, 32'h0);
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL tohost_zero: got %b want 0", halt); end
        wr(A_TOHOST, 4'hF, 32'h1);
        total++; if (halt !== 1'b1 || halt_code !== 32'h1) begin bad++; $display("FAIL tohost_set: got %b/%h want 1/1", halt, halt_code); end
        wr(A_TOHOST, 4'hF, 32'h5);
        total++; if (halt !== 1'b1 || halt_code !== 32'h1) begin bad++; $display("FAIL tohost_sticky: got %b/%h want 1/1", halt, halt_code); end
        rd(A_TOHOST);
        total++; if (memory_read_data !== 32'h1) begin bad++; $display("FAIL tohost_rd: got %h want 1", memory_read_data); end
        wr(A_SCRATCH, 4'hF, 32'hCAFEF00D);
        wr(A_SCRATCH, 4'b1100, 32'h12340000);
        rd(A_SCRATCH);
        total++; if (memory_read_data !== 32'h1234F00D) begin bad++; $display("FAIL scratch_be: got %h want 1234f00d", memory_read_data); end
    endtask

    task automatic test_reset_mid;
        wr(32'h400, 4'hF, 32'h0000A5A5);
        rd(32'h100);
        step(0, 1, 0, 32'h400, 4'hF, 32'h0);
        total++; if (memory_read_data !== 32'd0) begin bad++; $display("FAIL mid_rdata: got %h want 0", memory_read_data); end
        total++; if (halt !== 1'b0 || halt_code !== 32'd0) begin bad++; $display("FAIL mid_halt: got %b/%h want 0/0", halt, halt_code); end
        rd(A_CYC_LO);
        total++; if (memory_read_data !== 32'd0) begin bad++; $display("FAIL mid_cnt: got %0d want 0", memory_read_data); end
        rd(32'h400);
        total++; if (memory_read_data !== 32'h0000A5A5) begin bad++; $display("FAIL mid_ram400: got %h want a5a5", memory_read_data); end
        rd(32'h100);
        total++; if (memory_read_data !== 32'hDEADBEEF) begin bad++; $display("FAIL mid_ram100: got %h want deadbeef", memory_read_data); end
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [3:0]  offs [4] = '{4'h0, 4'h4, 4'h8, 4'hC};
        for (int i = 0; i < 16; i++) wr(32'h1000 + 32'(i * 4), 4'hF, $urandom);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(3, 0) == 0)
                a = {1'b1, 27'($urandom), offs[$urandom_range(3, 0)]};
            else
                a = 32'h1000 + 32'($urandom_range(15, 0) * 4) + 32'($urandom_range(3, 0))
                    + 32'($urandom_range(3, 0) * DEPTH * 4);
            step($urandom_range(63, 0) != 0, 1'($urandom), 1'($urandom), a, 4'($urandom), $urandom);
            if (m_rd_known) begin
                total++; if (memory_read_data !== m_rdata) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, memory_read_data, m_rdata); end
            end
            total++; if (halt !== m_halt) begin bad++; $display("FAIL rnd_halt[%0d]: got %b want %b", n, halt, m_halt); end
            total++; if (halt_code !== m_code) begin bad++; $display("FAIL rnd_code[%0d]: got %h want %h", n, halt_code, m_code); end
            total++; if (access_error !== m_err) begin bad++; $display("FAIL rnd_err[%0d]: got %b want %b", n, access_error, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_ram_basic();
        test_byte_enable();
        test_read_write_same();
        test_cycle();
        test_tohost();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
